// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory-bus DMA initiator and its bench.
// The word_align helper clears the byte-offset bits of a bus address.
package mem_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_GAP,
        WR_REQ,
        WR_GAP,
        FINISH
    } dma_state_t;

    localparam logic [3:0]  WSTRB_WORD = 4'b1111;
    localparam logic [3:0]  WSTRB_READ = 4'b0000;
    localparam logic [31:0] FB_ADDR    = 32'h0001_0000;
    localparam int unsigned FB_WORDS   = 14400;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_dma_initiator.sv
// Word fill / word copy engine on the picorv32 native memory interface.
// Define MEM_TIMEOUT_EN to build the per-transaction watchdog that aborts a stalled request.
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// RD_REQ | copy read in flight at src
// RD_GAP | request dropped for one cycle after the read
// WR_REQ | write in flight at dst (pattern or copied word)
// WR_GAP | request dropped for one cycle after the write, pick next step
// FINISH | first cycle drops busy, second cycle carries the done pulse
module mem_dma_initiator
    import mem_bus_pkg::*;
#(
    parameter int unsigned LEN_W          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_op,
    input  logic [31:0]      cmd_src,
    input  logic [31:0]      cmd_dst,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [31:0]      cmd_pattern,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic             mem_valid,
    output logic             mem_instr,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic             mem_ready,
    input  logic [31:0]      mem_rdata
);

    dma_state_t       state;
    dma_state_t       state_next;

    logic [29:0]      src_ptr;
    logic [29:0]      dst_ptr;
    logic [LEN_W-1:0] remaining;
    logic             op_copy;
    logic [31:0]      pattern;
    logic [31:0]      data_q;

    logic             accept;
    logic             issue_rd;
    logic             issue_wr;
    logic             rd_ack;
    logic             wr_ack;
    logic             to_hit;

    logic [29:0]      rd_ptr_sel;
    logic [29:0]      wr_ptr_sel;
    logic [31:0]      wr_data_sel;

    logic             unused_addr_bits;

    assign unused_addr_bits = ^{cmd_src[1:0], cmd_dst[1:0]};

    assign cmd_ready = (state == IDLE);
    assign mem_instr = 1'b0;
    assign accept    = cmd_valid && (state == IDLE);

    // On accept the command fields are used directly; afterwards the latched copies.
    assign rd_ptr_sel  = (state == IDLE) ? cmd_src[31:2] : src_ptr;
    assign wr_ptr_sel  = (state == IDLE) ? cmd_dst[31:2] : dst_ptr;
    assign wr_data_sel = (state == IDLE) ? cmd_pattern :
                         (op_copy ? data_q : pattern);

    always_comb begin
        state_next = state;
        issue_rd   = 1'b0;
        issue_wr   = 1'b0;
        rd_ack     = 1'b0;
        wr_ack     = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_len == '0) begin
                        state_next = FINISH;
                    end else if (cmd_op) begin
                        state_next = RD_REQ;
                        issue_rd   = 1'b1;
                    end else begin
                        state_next = WR_REQ;
                        issue_wr   = 1'b1;
                    end
                end
            end
            RD_REQ: begin
                if (mem_valid && mem_ready) begin
                    rd_ack     = 1'b1;
                    state_next = RD_GAP;
                end
            end
            RD_GAP: begin
                state_next = WR_REQ;
                issue_wr   = 1'b1;
            end
            WR_REQ: begin
                if (mem_valid && mem_ready) begin
                    wr_ack     = 1'b1;
                    state_next = WR_GAP;
                end
            end
            WR_GAP: begin
                if (remaining == '0) begin
                    state_next = FINISH;
                end else if (op_copy) begin
                    state_next = RD_REQ;
                    issue_rd   = 1'b1;
                end else begin
                    state_next = WR_REQ;
                    issue_wr   = 1'b1;
                end
            end
            FINISH: begin
                if (done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (to_hit) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= WSTRB_READ;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
            op_copy   <= 1'b0;
            pattern   <= '0;
            data_q    <= '0;
        end else begin
            done <= (state == FINISH) && !done;

            if (accept) begin
                busy      <= 1'b1;
                src_ptr   <= cmd_src[31:2];
                dst_ptr   <= cmd_dst[31:2];
                remaining <= cmd_len;
                op_copy   <= cmd_op;
                pattern   <= cmd_pattern;
            end

            if (((state == FINISH) && !done) || to_hit) begin
                busy <= 1'b0;
            end

            if (issue_rd) begin
                mem_valid <= 1'b1;
                mem_addr  <= {rd_ptr_sel, 2'b00};
                mem_wstrb <= WSTRB_READ;
            end

            if (issue_wr) begin
                mem_valid <= 1'b1;
                mem_addr  <= {wr_ptr_sel, 2'b00};
                mem_wdata <= wr_data_sel;
                mem_wstrb <= WSTRB_WORD;
            end

            if (rd_ack) begin
                mem_valid <= 1'b0;
                data_q    <= mem_rdata;
            end

            // Pointers are word indices, so +1 is a 4-byte step wrapping at 2^32.
            if (wr_ack) begin
                mem_valid <= 1'b0;
                dst_ptr   <= dst_ptr + 30'd1;
                remaining <= remaining - 1'b1;
                if (op_copy) begin
                    src_ptr <= src_ptr + 30'd1;
                end
            end

            if (to_hit) begin
                mem_valid <= 1'b0;
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt;

    // Abort on the edge that would bring the count to TIMEOUT_CYCLES,
    // so the request is held for exactly TIMEOUT_CYCLES cycles.
    assign to_hit = mem_valid && !mem_ready && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
            error  <= 1'b0;
        end else begin
            error <= to_hit;
            if (issue_rd || issue_wr) begin
                to_cnt <= '0;
            end else if (mem_valid && !mem_ready) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
        end
    end
`else
    assign to_hit = 1'b0;
    assign error  = 1'b0;
`endif

endmodule

// File: doc/mem_dma_initiator.md
Name: mem_dma_initiator

Overview:
- Bus-initiator engine on the picorv32 native memory interface (mem_valid/mem_addr/mem_wdata/mem_wstrb, answered by mem_ready/mem_rdata).
- Performs word fills, e.g. clearing the 320x180 framebuffer at 'h10000, and word copies (src to dst) without CPU involvement.
- Sits beside the CPU in front of the main-memory responder; an external arbiter selects between CPU and DMA. The arbiter is outside this block.

Parameters:
- LEN_W, 16: width of the word-count field; max transfer is 2^LEN_W-1 words.
- TIMEOUT_CYCLES, 255: watchdog limit per bus transaction, in cycles. Used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  engine can accept a command; combinational, equals (state==IDLE).
- cmd_op  in  1  0 = fill, 1 = copy.
- cmd_src  in  32  copy source byte address; word-aligned, bits [1:0] ignored.
- cmd_dst  in  32  destination byte address; word-aligned, bits [1:0] ignored.
- cmd_len  in  LEN_W  number of 32-bit words.
- cmd_pattern  in  32  fill word.
- busy  out  1  high from command accept until done.
- done  out  1  one-cycle pulse when the command completes.
- error  out  1  one-cycle pulse on timeout abort; tied 0 without MEM_TIMEOUT_EN.
- mem_valid  out  1  transaction request.
- mem_instr  out  1  constant 0.
- mem_addr  out  32  word address.
- mem_wdata  out  32  write data.
- mem_wstrb  out  4  4'b1111 for writes, 4'b0000 for reads.
- mem_ready  in  1  responder completion.
- mem_rdata  in  32  read data, valid when mem_ready=1.

Behaviour:
- Reset values: busy=0, done=0, error=0, mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, state=IDLE, counters=0.
- States: IDLE, RD_REQ, RD_GAP, WR_REQ, WR_GAP, FINISH.
- Accept: cmd_valid & cmd_ready at an edge latches src, dst, len, op and pattern.
  - len=0: go to FINISH, issue no bus traffic.
  - fill: go to WR_REQ.
  - copy: go to RD_REQ.
  - mem_valid rises in the cycle after accept (1-cycle latency).
- Handshake:
  - mem_valid, mem_addr, mem_wdata and mem_wstrb are held stable while mem_valid=1.
  - At the edge where mem_ready=1 is sampled, mem_valid drops.
  - Each transaction is followed by at least one cycle with mem_valid=0 (the *_GAP states). This guarantees the responder sees the deasserted request.
  - mem_ready seen while mem_valid=0 is ignored.
- RD_REQ:
  - mem_addr=src, wstrb=0.
  - On mem_ready: latch mem_rdata into the data register, then go to RD_GAP and then WR_REQ.
- WR_REQ:
  - mem_addr=dst, wstrb=4'b1111, mem_wdata = pattern (fill) or the data register (copy).
  - On mem_ready: dst+=4, src+=4 (copy only), remaining-=1, then go to WR_GAP.
  - From WR_GAP: go to FINISH if remaining==0, else to RD_REQ (copy) or WR_REQ (fill).
- Address arithmetic: 32-bit, wraps modulo 2^32 with no error.
- Overlap between the src and dst regions is not detected. Copy proceeds in ascending address order.
- FINISH: done=1 for one cycle, busy=0, then IDLE. cmd_ready is 1 again in the cycle after the done pulse.
- cmd_valid while busy: ignored; no queueing.
- Reset mid-transfer:
  - At the reset edge, mem_valid goes to 0 and the state returns to IDLE.
  - No done pulse is produced; the partial transfer is abandoned.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- With the macro defined:
  - A per-transaction counter clears whenever mem_valid rises and increments each cycle mem_valid=1 & mem_ready=0.
  - When the counter reaches TIMEOUT_CYCLES: mem_valid drops, error pulses for 1 cycle, the state goes to IDLE, and no done pulse is produced.
- Without the macro: no counter is built, error is tied 0, and the engine waits indefinitely.

Decomposition:
- Shared package mem_bus_pkg holds:
  - typedef enum dma_state_t;
  - constants WSTRB_WORD=4'b1111, WSTRB_READ=4'b0000, FB_ADDR='h10000, FB_WORDS=14400.
- No sub-module is needed; the FSM plus datapath fit in one module. The bench reuses a separate behavioural mem_responder model with configurable ready latency.

Test Plan:
- Fill: dst='h10000, len=4, pattern='hDEADBEEF, responder latency 7 -> 4 writes to 'h10000..'h1000C, each wstrb=1111, ≥1 idle cycle between writes, single done pulse, memory holds the pattern.
- Copy: src='h100, dst='h200, len=3, memory preloaded 1,2,3 -> access order R100, W200, R104, W204, R108, W208; 'h200..'h208 = 1,2,3; done once.
- len=0: cmd accepted -> no mem_valid ever asserted; done pulses 2 cycles after accept; busy high for 1 cycle only.
- Wrap: dst='hFFFFFFFC, len=2 fill -> writes to 'hFFFFFFFC then 'h00000000; no error.
- Reset mid-copy: assert rst while mem_valid=1 on the 2nd read -> mem_valid=0 next cycle, cmd_ready=1, no done; a new fill then completes normally.
- MEM_TIMEOUT_EN with TIMEOUT_CYCLES=8 and a responder that never answers -> mem_valid drops after 8 cycles, error pulses once, no done, cmd_ready returns to 1.
